// File: rtl/pipelined_lookahead_adder_pkg.sv
// Shared defaults and helpers for the pipelined lookahead adder.
// Provides width defaults and the stage-count function.
package pipelined_lookahead_adder_pkg;

  localparam int N_DEF   = 8;
  localparam int SEG_DEF = 4;

  function automatic int stages_of(int n, int seg);
    return n / seg;
  endfunction

endpackage

// File: rtl/pipelined_lookahead_adder_cla_segment.sv
// cla_segment: combinational SEG-bit carry-lookahead slice.
// Ports: a, b, cin in; s (sum slice), cout out.
module cla_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout
);

  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the flat OR of generate terms gated by the
  // propagate chain below them, so no carry ripples in the slice.
  always_comb begin
    logic acc;
    logic pp;
    c    = '0;
    acc  = 1'b0;
    pp   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & cin);
    end
  end

  assign s    = p ^ c[SEG-1:0];
  assign cout = c[SEG];

endmodule

// File: rtl/pipelined_lookahead_adder.sv
// Pipelined lookahead add/sub, one SEG-bit segment per stage, valid/ready both sides.
// Ports: clk, rst_n, in_valid/in_ready, a, b, ci, sub, out_valid/out_ready, sum, co, ovf; op_count with ADDER_STATS_EN.
module pipelined_lookahead_adder
  import pipelined_lookahead_adder_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int SEG = SEG_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         co,
`ifdef ADDER_STATS_EN
  output logic [31:0]  op_count,
`endif
  output logic         ovf
);

  localparam int STAGES = stages_of(N, SEG);

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] bx;
    logic [N-1:0] s;
    logic         c;
  } beat_t;

  beat_t [STAGES-1:0] st_q;
  beat_t [STAGES-1:0] st_d;
  logic  [STAGES-1:0] vld_q;
  logic  [STAGES-1:0] adv;
  logic  [STAGES-1:0] mv;

  logic [N-1:0] bx_in;
  logic         cin;

  assign bx_in = sub ? ~b : b;
  assign cin   = sub ? ~ci : ci;

  // mv[k]: stage k hands its beat on; adv[k]: stage k loads.
  // Resolved from the output end back so a full pipe can
  // still accept when the sink takes a beat.
  always_comb begin
    mv  = '0;
    adv = '0;
    mv[STAGES-1] = vld_q[STAGES-1] & out_ready;
    for (int k = STAGES - 1; k >= 1; k--) begin
      adv[k]  = vld_q[k-1] & (~vld_q[k] | mv[k]);
      mv[k-1] = adv[k];
    end
    in_ready = ~vld_q[0] | mv[0];
    adv[0]   = in_valid & in_ready;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [N-1:0]   a_k;
    logic [N-1:0]   bx_k;
    logic [N-1:0]   s_k;
    logic           scin;
    logic [SEG-1:0] ss;
    logic           scout;

    if (k == 0) begin : g_first
      assign a_k  = a;
      assign bx_k = bx_in;
      assign s_k  = '0;
      assign scin = cin;
    end else begin : g_next
      assign a_k  = st_q[k-1].a;
      assign bx_k = st_q[k-1].bx;
      assign s_k  = st_q[k-1].s;
      assign scin = st_q[k-1].c;
    end

    cla_segment #(.SEG(SEG)) u_cla (
      .a    (a_k[k*SEG +: SEG]),
      .b    (bx_k[k*SEG +: SEG]),
      .cin  (scin),
      .s    (ss),
      .cout (scout)
    );

    // Slice k of s_k is still zero, so OR merges the new slice.
    assign st_d[k] = '{
      a:  a_k,
      bx: bx_k,
      s:  s_k | (N'(ss) << (k * SEG)),
      c:  scout
    };
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      st_q  <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          vld_q[k] <= 1'b1;
          st_q[k]  <= st_d[k];
        end else if (mv[k]) begin
          vld_q[k] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = st_q[STAGES-1].s;
  assign co        = st_q[STAGES-1].c;
  assign ovf       = (st_q[STAGES-1].a[N-1] == st_q[STAGES-1].bx[N-1])
                   && (st_q[STAGES-1].s[N-1] != st_q[STAGES-1].a[N-1]);

  // Only the sign bits of the last stage's operands are consumed.
  logic unused_ops;
  assign unused_ops = ^{st_q[STAGES-1].a, st_q[STAGES-1].bx};

`ifdef ADDER_STATS_EN
  logic [31:0] op_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      op_cnt_q <= op_cnt_q + 32'd1;
    end
  end

  assign op_count = op_cnt_q;
`endif

  a_in_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    (in_valid && !in_ready) |=> (in_valid && $stable({a, b, ci, sub}))
  );

endmodule

// File: tb/tb_pipelined_lookahead_adder.sv
// Bench for pipelined_lookahead_adder: directed cases plus random traffic.
// Results are compared against an arithmetic reference model via a queue.
module tb_pipelined_lookahead_adder;

  localparam int N      = 8;
  localparam int SEG    = 4;
  localparam int STAGES = N / SEG;
  localparam int NBEATS = 3000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ci;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         co;
  logic         ovf;
`ifdef ADDER_STATS_EN
  logic [31:0]  op_count;
`endif

  pipelined_lookahead_adder #(.N(N), .SEG(SEG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
`ifdef ADDER_STATS_EN
    .op_count  (op_count),
`endif
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // {co, ovf, sum} from plain integer arithmetic.
  function automatic logic [N+1:0] ref_op(input logic [N-1:0] x,
                                          input logic [N-1:0] y,
                                          input logic c, input logic s);
    longint ux, uy, sx, sy, r, sr;
    logic   rco, rov;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!s) begin
      r   = ux + uy + longint'(c);
      rco = (r >= (longint'(1) << N));
      sr  = sx + sy + longint'(c);
    end else begin
      r   = ux - uy - longint'(c);
      rco = (ux >= uy + longint'(c));
      sr  = sx - sy - longint'(c);
    end
    rov = (sr > (longint'(1) << (N-1)) - 1) || (sr < -(longint'(1) << (N-1)));
    return {rco, rov, N'(r)};
  endfunction

  logic [N+1:0] q[$];
  logic         stall_q = 1'b0;
  logic [N+2:0] held;

  always @(negedge clk) begin
    logic [N+1:0] e;
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q)
        check("hold", {out_valid, co, ovf, sum}, held);
      if (in_valid && in_ready)
        q.push_back(ref_op(a, b, ci, sub));
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          check("spurious", 1, 0);
        end else begin
          e = q.pop_front();
          check("result", {co, ovf, sum}, e);
        end
      end
      stall_q = out_valid && !out_ready;
      held    = {out_valid, co, ovf, sum};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string tag);
    int t;
    bit ok;
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = in_ready;
      step();
      t++;
    end
    if (!ok) check({tag, "_acc_timeout"}, 0, 1);
  endtask

  task automatic run_one(input logic [N-1:0] ta, input logic [N-1:0] tb,
                         input logic tci, input logic tsub,
                         input logic [N+1:0] exp, input string tag);
    int t;
    a = ta; b = tb; ci = tci; sub = tsub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    wait_accept(tag);
    in_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 20) begin
      t++;
      @(negedge clk);
    end
    check({tag, "_lat"}, t, STAGES - 1);
    check({tag, "_res"}, {co, ovf, sum}, exp);
    step();
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (q.size() != 0 && t < 100) begin
      step();
      t++;
    end
    check({tag, "_drain"}, q.size(), 0);
  endtask

  function automatic logic [N-1:0] pick();
    logic [N-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(N-1){1'b0}}};
      3:       v = {1'b0, {(N-1){1'b1}}};
      default: v = N'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    int sent;
    int cyc;
    bit acc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; ci = 1'b0; sub = 1'b0;

    @(negedge clk);
    check("rst_ovalid", out_valid, 0);
    check("rst_sum", {co, ovf, sum}, 0);
`ifdef ADDER_STATS_EN
    check("rst_opcnt", op_count, 0);
`endif
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_iready", in_ready, 1);
    step();

    run_one(8'hFF, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h00}, "wrap");
    run_one(8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 1'b0, 8'hFE}, "borrow");
    run_one(8'h7F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h80}, "ovf_add");
    run_one(8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F}, "ovf_sub");
    run_one(8'h10, 8'h0F, 1'b1, 1'b1, {1'b1, 1'b0, 8'h00}, "sub_ci");

    // Backpressure: fill the pipe, hold it, then release.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 8'h10; b = 8'h01; ci = 1'b0; sub = 1'b0;
    @(negedge clk);
    check("bp_rdy0", in_ready, 1);
    step();
    a = 8'h20; b = 8'h02;
    @(negedge clk);
    check("bp_rdy1", in_ready, 1);
    step();
    a = 8'h30; b = 8'h03;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_full", in_ready, 0);
      check("bp_out", {out_valid, sum}, {1'b1, 8'h11});
      step();
    end
    out_ready = 1'b1;
    wait_accept("bp");
    in_valid = 1'b0;
    drain("bp");

    // Reset with two beats in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 8'h01; b = 8'h02; ci = 1'b0; sub = 1'b0;
    step();
    a = 8'h03;
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ovalid", out_valid, 0);
    q.delete();
    n_out = 0;
    step();
`ifdef ADDER_STATS_EN
    check("mid_rst_opcnt", op_count, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst", {in_ready, out_valid}, 2'b10);
    step();
    run_one(8'h01, 8'h01, 1'b0, 1'b0, {1'b0, 1'b0, 8'h02}, "post_rst");

    // Random traffic with random backpressure.
    sent = 0;
    cyc  = 0;
    acc  = 1'b0;
    in_valid = 1'b0;
    while (sent < NBEATS && cyc < 40000) begin
      if (!in_valid || acc) begin
        if (sent < NBEATS && $urandom_range(0, 3) != 0) begin
          a   = pick();
          b   = pick();
          ci  = 1'($urandom);
          sub = 1'($urandom);
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      step();
      cyc++;
    end
    check("rand_sent", sent, NBEATS);
    drain("rand");
`ifdef ADDER_STATS_EN
    check("opcnt", op_count, n_out);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
